// File: rtl/request_unit.sv
// Fetch/data request sequencer: issues instruction fetches, one outstanding data
// access at a time, and parks in a sticky halt until reset.
module request_unit #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             mem_halt,
    input  logic             ihit,
    input  logic             dhit,
    output logic             iREN,
    output logic             dREN,
    output logic             dWEN,
    output logic             PC_EN,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic               dren_r;
    logic               dwen_r;
    logic               dren_next_s;
    logic               dwen_next_s;
    logic               iren_r;
    logic               halt_r;
    logic               pc_en_s;
    logic [CNT_W-1:0]   cnt_r;

    // Next-state, next data request and same-cycle PC strobe
    always_comb begin
        next_state_s = state_r;
        dren_next_s  = dren_r;
        dwen_next_s  = dwen_r;
        pc_en_s      = 1'b0;
        case (state_r)
            IDLE: begin
                dren_next_s = 1'b0;
                dwen_next_s = 1'b0;
                if (ihit) begin
                    if (mem_halt) begin
                        next_state_s = HALTED;
                    end else if (MemRead || MemWrite) begin
                        // A store wins over a load on an illegal double decode
                        next_state_s = DWAIT;
                        dwen_next_s  = MemWrite;
                        dren_next_s  = MemRead & ~MemWrite;
                    end else begin
                        pc_en_s = 1'b1;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            DWAIT: begin
                if (dhit) begin
                    pc_en_s      = 1'b1;
                    next_state_s = IDLE;
                    dren_next_s  = 1'b0;
                    dwen_next_s  = 1'b0;
                end else begin
                    next_state_s = DWAIT;
                end
            end
            HALTED: begin
                next_state_s = HALTED;
                dren_next_s  = 1'b0;
                dwen_next_s  = 1'b0;
            end
            default: begin
                next_state_s = IDLE;
                dren_next_s  = 1'b0;
                dwen_next_s  = 1'b0;
            end
        endcase
    end

    // State, request and status registers; iREN/halt are pre-decoded from next state
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            dren_r  <= 1'b0;
            dwen_r  <= 1'b0;
            iren_r  <= 1'b1;
            halt_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            dren_r  <= dren_next_s;
            dwen_r  <= dwen_next_s;
            iren_r  <= (next_state_s == IDLE);
            halt_r  <= (next_state_s == HALTED);
        end
    end

    // Stall counter: counts non-advancing cycles, wraps naturally, frozen once halted
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!pc_en_s && (state_r != HALTED)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign iREN      = iren_r;
    assign dREN      = dren_r;
    assign dWEN      = dwen_r;
    assign halt      = halt_r;
    assign PC_EN     = pc_en_s;
    assign stall_cnt = cnt_r;

endmodule

// File: tb/tb_request_unit.sv
// Directed bench for request_unit with a 4-bit stall counter so wrap is reachable.
module tb_request_unit;

    localparam int CNT_W = 4;

    logic             CLK;
    logic             RST;
    logic             MemRead;
    logic             MemWrite;
    logic             mem_halt;
    logic             ihit;
    logic             dhit;
    logic             iREN;
    logic             dREN;
    logic             dWEN;
    logic             PC_EN;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;

    int n_cmp;
    int n_err;

    request_unit #(.CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .mem_halt  (mem_halt),
        .ihit      (ihit),
        .dhit      (dhit),
        .iREN      (iREN),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .PC_EN     (PC_EN),
        .halt      (halt),
        .stall_cnt (stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        mem_halt = 1'b0;
        ihit     = 1'b0;
        dhit     = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        RST   = 1'b1;
        idle_inputs();
        tick();
        tick();

        // Reset state
        check_val("rst_iren", {31'd0, iREN}, 32'd1);
        check_val("rst_dren", {31'd0, dREN}, 32'd0);
        check_val("rst_dwen", {31'd0, dWEN}, 32'd0);
        check_val("rst_halt", {31'd0, halt}, 32'd0);
        check_val("rst_pcen", {31'd0, PC_EN}, 32'd0);
        check_val("rst_cnt", {28'd0, stall_cnt}, 32'd0);

        // Counter wrap: 17 stalled edges -> 15, 0, then 1
        RST = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 15) check_val("wrap_15", {28'd0, stall_cnt}, 32'd15);
            if (i == 16) check_val("wrap_0", {28'd0, stall_cnt}, 32'd0);
            if (i == 17) check_val("wrap_1", {28'd0, stall_cnt}, 32'd1);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_val("rst2_cnt", {28'd0, stall_cnt}, 32'd0);

        // ALU instruction advances PC in the same cycle, no stall
        ihit = 1'b1;
        #1;
        check_val("alu_pcen", {31'd0, PC_EN}, 32'd1);
        tick();
        ihit = 1'b0;
        #1;
        check_val("alu_iren", {31'd0, iREN}, 32'd1);
        check_val("alu_dren", {31'd0, dREN}, 32'd0);
        check_val("alu_cnt", {28'd0, stall_cnt}, 32'd0);

        // Load, dhit on third DWAIT cycle; ihit held high to show it is ignored
        ihit    = 1'b1;
        MemRead = 1'b1;
        #1;
        check_val("ld_pcen0", {31'd0, PC_EN}, 32'd0);
        tick();
        MemRead = 1'b0;
        #1;
        check_val("ld_dren", {31'd0, dREN}, 32'd1);
        check_val("ld_dwen", {31'd0, dWEN}, 32'd0);
        check_val("ld_iren", {31'd0, iREN}, 32'd0);
        check_val("ld_wait_pcen", {31'd0, PC_EN}, 32'd0);
        tick();
        tick();
        check_val("ld_dren_hold", {31'd0, dREN}, 32'd1);
        dhit = 1'b1;
        #1;
        check_val("ld_dhit_pcen", {31'd0, PC_EN}, 32'd1);
        tick();
        ihit = 1'b0;
        dhit = 1'b0;
        #1;
        check_val("ld_done_dren", {31'd0, dREN}, 32'd0);
        check_val("ld_done_iren", {31'd0, iREN}, 32'd1);
        check_val("ld_cnt", {28'd0, stall_cnt}, 32'd3);

        // Store with illegal double decode: store wins
        ihit     = 1'b1;
        MemRead  = 1'b1;
        MemWrite = 1'b1;
        tick();
        idle_inputs();
        #1;
        check_val("st_dwen", {31'd0, dWEN}, 32'd1);
        check_val("st_dren", {31'd0, dREN}, 32'd0);
        check_val("st_iren", {31'd0, iREN}, 32'd0);
        dhit = 1'b1;
        tick();
        dhit = 1'b0;
        #1;
        check_val("st_done_dwen", {31'd0, dWEN}, 32'd0);
        check_val("st_done_iren", {31'd0, iREN}, 32'd1);
        check_val("st_cnt", {28'd0, stall_cnt}, 32'd4);

        // Halt wins over a simultaneous store decode
        ihit     = 1'b1;
        mem_halt = 1'b1;
        MemWrite = 1'b1;
        #1;
        check_val("hlt_pcen", {31'd0, PC_EN}, 32'd0);
        tick();
        idle_inputs();
        #1;
        check_val("hlt_halt", {31'd0, halt}, 32'd1);
        check_val("hlt_dwen", {31'd0, dWEN}, 32'd0);
        check_val("hlt_iren", {31'd0, iREN}, 32'd0);
        check_val("hlt_cnt", {28'd0, stall_cnt}, 32'd5);
        for (int i = 0; i < 10; i++) begin
            ihit    = (i % 2 == 0);
            dhit    = (i % 2 == 1);
            MemRead = (i % 3 == 0);
            #1;
            check_val("hlt_loop_pcen", {31'd0, PC_EN}, 32'd0);
            tick();
        end
        idle_inputs();
        #1;
        check_val("hlt_frz_outs", {28'd0, iREN, dREN, dWEN, PC_EN}, 32'd0);
        check_val("hlt_frz_halt", {31'd0, halt}, 32'd1);
        check_val("hlt_frz_cnt", {28'd0, stall_cnt}, 32'd5);

        // Reset out of HALTED
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        check_val("hrst_halt", {31'd0, halt}, 32'd0);
        check_val("hrst_iren", {31'd0, iREN}, 32'd1);
        check_val("hrst_cnt", {28'd0, stall_cnt}, 32'd0);

        // Reset with a load outstanding; request must not be reissued
        ihit    = 1'b1;
        MemRead = 1'b1;
        tick();
        idle_inputs();
        #1;
        check_val("mrst_pre_dren", {31'd0, dREN}, 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        check_val("mrst_dren", {31'd0, dREN}, 32'd0);
        check_val("mrst_iren", {31'd0, iREN}, 32'd1);
        check_val("mrst_cnt", {28'd0, stall_cnt}, 32'd0);
        tick();
        check_val("mrst_noreissue", {31'd0, dREN}, 32'd0);
        check_val("mrst_post_cnt", {28'd0, stall_cnt}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
